game_state_controller: RTL and testbench

GAME_STATE_CONTROLLER -- requirements
Module: game_state_controller

---
 rtl/game_state_controller.sv | 163 ++++++++++++++++
 tb/tb_game_state_controller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_controller.sv
// Purpose : game-flow FSM (IDLE/RUN/CRASH/OVER) with tick divider, lives and BCD score.
// Latency : all outputs registered or decoded from flops; pulses and state changes 1 cycle after cause.
// Backpres: none; start and colision are sampled every cycle and never stalled.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 level-sampled start request (honoured in IDLE and OVER)
//   colision              player/obstacle overlap; a rising edge in RUN crashes
//   upsig / upsig_fast    one-cycle slow / fast update pulses, only while in RUN
//   state                 IDLE=00 RUN=01 CRASH=10 OVER=11
//   lives, score          remaining lives, four-digit BCD score
//   blink                 player flash enable while crashed
module game_state_controller #(
    parameter int unsigned FAST_DIV    = 833333,
    parameter int unsigned CRASH_TICKS = 90,
    parameter int unsigned LIVES       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        colision,
    output logic        upsig,
    output logic        upsig_fast,
    output logic [1:0]  state,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic        blink
);

    localparam int unsigned          DIV_W   = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_MAX = DIV_W'(FAST_DIV - 1);
    localparam logic [7:0]           CRASH_LD = 8'(CRASH_TICKS);
    localparam logic [1:0]           LIVES_LD = 2'(LIVES);
    localparam logic [15:0]          SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CRASH = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               phase_q, phase_d;
    logic [1:0]         lives_q, lives_d;
    logic [15:0]        score_q, score_d;
    logic [15:0]        score_inc;
    logic [7:0]         crash_cnt_q, crash_cnt_d;
    logic               colision_q;
    logic               upsig_q, upsig_d;
    logic               upsig_fast_q, upsig_fast_d;

    logic               ftick;
    logic               col_rise;
    logic               bcd_carry;

    assign ftick    = (div_q == DIV_MAX);
    assign col_rise = colision & ~colision_q;

    // State register: every flop in the block lives here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            phase_q      <= 1'b0;
            lives_q      <= 2'd0;
            score_q      <= 16'h0000;
            crash_cnt_q  <= 8'd0;
            colision_q   <= 1'b0;
            upsig_q      <= 1'b0;
            upsig_fast_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            crash_cnt_q  <= crash_cnt_d;
            colision_q   <= colision;
            upsig_q      <= upsig_d;
            upsig_fast_q <= upsig_fast_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (col_rise) state_d = ST_CRASH;
            end
            ST_CRASH: begin
                // Leave on the tick that takes the counter from 1 to 0.
                if (ftick && (crash_cnt_q == 8'd1)) begin
                    state_d = (lives_q == 2'd0) ? ST_OVER : ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ripple BCD increment; each digit wraps 9->0 and passes the carry up.
    always_comb begin
        score_inc = score_q;
        bcd_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bcd_carry) begin
                if (score_q[i*4 +: 4] == 4'd9) begin
                    score_inc[i*4 +: 4] = 4'd0;
                end else begin
                    score_inc[i*4 +: 4] = score_q[i*4 +: 4] + 4'd1;
                    bcd_carry = 1'b0;
                end
            end
        end
    end

    // Datapath next values: divider, phase, pulses, lives, score, crash timer.
    always_comb begin
        div_d        = ftick ? '0 : div_q + DIV_W'(1);
        phase_d      = phase_q ^ ftick;
        upsig_fast_d = ftick & (state_q == ST_RUN);
        upsig_d      = ftick & phase_q & (state_q == ST_RUN);
        lives_d      = lives_q;
        score_d      = score_q;
        crash_cnt_d  = crash_cnt_q;
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score_d = 16'h0000;
                    lives_d = LIVES_LD;
                end
            end
            ST_RUN: begin
                // Score follows upsig_fast even when a crash lands on the same edge.
                if (ftick && (score_q != SCORE_MAX)) score_d = score_inc;
                if (col_rise) begin
                    lives_d     = lives_q - 2'd1;
                    crash_cnt_d = CRASH_LD;
                end
            end
            ST_CRASH: begin
                if (ftick) crash_cnt_d = crash_cnt_q - 8'd1;
            end
            default: ;
        endcase
    end

    // Outputs: decoded from flops only.
    always_comb begin
        state      = state_q;
        lives      = lives_q;
        score      = score_q;
        upsig      = upsig_q;
        upsig_fast = upsig_fast_q;
        blink      = (state_q == ST_CRASH) & crash_cnt_q[2];
    end

endmodule

// File: tb/tb_game_state_controller.sv
module tb_game_state_controller;

    localparam int FD = 4;
    localparam int CT = 6;
    localparam int LV = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        colision;
    logic        upsig;
    logic        upsig_fast;
    logic [1:0]  state;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        blink;
    logic [22:0] obs_w;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (values the DUT flops should hold after the last edge).
    int m_div, m_phase, m_state, m_lives, m_score, m_cc, m_colq, m_ups, m_upf;
    logic [22:0] exp_q[$];

    game_state_controller #(
        .FAST_DIV   (FD),
        .CRASH_TICKS(CT),
        .LIVES      (LV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .colision  (colision),
        .upsig     (upsig),
        .upsig_fast(upsig_fast),
        .state     (state),
        .lives     (lives),
        .score     (score),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    assign obs_w = {state, lives, score, upsig, upsig_fast, blink};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [22:0] model_pack();
        logic blk;
        blk = (m_state == 2) && ((m_cc & 4) != 0);
        return {2'(m_state), 2'(m_lives), to_bcd(m_score), m_ups != 0, m_upf != 0, blk};
    endfunction

    task automatic model_reset();
        m_div = 0; m_phase = 0; m_state = 0; m_lives = 0; m_score = 0;
        m_cc = 0; m_colq = 0; m_ups = 0; m_upf = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock edge given the inputs for that edge.
    task automatic model_step(input logic st, input logic col);
        bit ft, rise;
        ft     = (m_div == FD - 1);
        m_div  = ft ? 0 : m_div + 1;
        rise   = col && (m_colq == 0);
        m_colq = col;
        m_upf  = (ft && m_state == 1) ? 1 : 0;
        m_ups  = (ft && m_phase == 1 && m_state == 1) ? 1 : 0;
        if (ft) m_phase = 1 - m_phase;
        case (m_state)
            0, 3: if (st) begin m_state = 1; m_score = 0; m_lives = LV; end
            1: begin
                if (ft && m_score < 9999) m_score++;
                if (rise) begin m_state = 2; m_lives--; m_cc = CT; end
            end
            2: if (ft) begin
                m_cc--;
                if (m_cc == 0) m_state = (m_lives == 0) ? 3 : 1;
            end
            default: ;
        endcase
        exp_q.push_back(model_pack());
    endtask

    // Called at a falling edge: drive inputs, predict, let the edge happen, compare.
    task automatic cycle(input logic st, input logic col);
        logic [22:0] e;
        start    = st;
        colision = col;
        model_step(st, col);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("cycle", 32'(obs_w), 32'(e));
    endtask

    // Asserts reset between edges, checks the asynchronous clear, then releases.
    task automatic do_reset();
        #2;
        reset    = 1'b1;
        start    = 1'b0;
        colision = 1'b0;
        #1;
        chk("rst_async", 32'(obs_w), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold", 32'(obs_w), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int nf, ns, guard, sc;
        bit saw_hi, saw_lo;
        reset    = 1'b1;
        start    = 1'b0;
        colision = 1'b0;
        model_reset();
        @(negedge clk);

        // Tick rate
        do_reset();
        repeat (3) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("start_state", 32'(state), 32'd1);
        chk("start_lives", 32'(lives), 32'(LV));
        chk("start_score", 32'(score), 32'h0);
        nf = 0; ns = 0;
        repeat (40) begin
            cycle(1'b0, 1'b0);
            nf += int'(upsig_fast);
            ns += int'(upsig);
        end
        chk("fast_cnt", 32'(nf), 32'd10);
        chk("slow_cnt", 32'(ns), 32'd5);
        chk("score10", 32'(score), 32'h0010);

        // Crash and recover while colision stays high
        cycle(1'b0, 1'b1);
        chk("crash_state", 32'(state), 32'd2);
        chk("crash_lives", 32'(lives), 32'd1);
        saw_hi = 0; saw_lo = 0;
        for (int i = 0; i < 100 && state == 2'b10; i++) begin
            if (blink) saw_hi = 1; else saw_lo = 1;
            cycle(1'b1, 1'b1);
        end
        chk("crash_exit", 32'(state), 32'd1);
        chk("blink_seen", 32'({saw_hi, saw_lo}), 32'd3);
        repeat (30) cycle(1'b0, 1'b1);
        chk("no_recrash", 32'(state), 32'd1);
        chk("held_lives", 32'(lives), 32'd1);

        // Game over
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        chk("crash2_state", 32'(state), 32'd2);
        chk("crash2_lives", 32'(lives), 32'd0);
        for (int i = 0; i < 100 && state == 2'b10; i++) cycle(1'b0, 1'b0);
        chk("over_state", 32'(state), 32'd3);
        chk("over_lives", 32'(lives), 32'd0);
        nf = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'(i % 2));
            nf += int'(upsig) + int'(upsig_fast);
        end
        chk("over_quiet", 32'(nf), 32'd0);
        chk("over_held", 32'(state), 32'd3);
        cycle(1'b1, 1'b0);
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_lives", 32'(lives), 32'(LV));
        chk("restart_score", 32'(score), 32'h0);

        // BCD carry and saturation
        do_reset();
        cycle(1'b1, 1'b0);
        guard = 0;
        while (m_score < 99 && guard < 2000) begin cycle(1'b0, 1'b0); guard++; end
        chk("bcd_0099", 32'(score), 32'h0099);
        while (m_score < 100 && guard < 2000) begin cycle(1'b0, 1'b0); guard++; end
        chk("bcd_0100", 32'(score), 32'h0100);
        guard = 0;
        while (m_score < 9999 && guard < 50000) begin cycle(1'b0, 1'b0); guard++; end
        chk("bcd_9999", 32'(score), 32'h9999);
        nf = 0;
        repeat (40) begin cycle(1'b0, 1'b0); nf += int'(upsig_fast); end
        chk("sat_pulses", 32'(nf), 32'd10);
        chk("sat_score", 32'(score), 32'h9999);

        // Collision rising on the same edge as a fast tick, then reset in CRASH
        do_reset();
        cycle(1'b1, 1'b0);
        repeat (5) cycle(1'b0, 1'b0);
        for (int i = 0; i < 8 && m_div != FD - 1; i++) cycle(1'b0, 1'b0);
        sc = m_score;
        cycle(1'b0, 1'b1);
        chk("coin_upf", 32'(upsig_fast), 32'd1);
        chk("coin_state", 32'(state), 32'd2);
        chk("coin_score", 32'(score), 32'(to_bcd(sc + 1)));
        repeat (3) cycle(1'b0, 1'b1);
        chk("pre_rst_state", 32'(state), 32'd2);
        do_reset();
        repeat (6) cycle(1'b0, 1'b0);
        chk("post_rst_state", 32'(state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
